// File: rtl/ram_dp_clr.sv
// ============================================================================
// Module   : ram_dp_clr
// Brief    : Simple-dual-port RAM with bit mask, selectable read latency,
//            read-during-write mode and a zeroing clear sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_dp_clr #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_MODE    = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int                    c_DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST     = {ADDR_WIDTH{1'b1}};
  localparam logic [0:0]            c_ST_CLEAR = 1'b0;
  localparam logic [0:0]            c_ST_READY = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  w_clearing;
  logic                  w_accept;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  w_out_valid;
  logic [DATA_WIDTH-1:0] w_out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_CLEAR: if (r_clr_cnt == c_LAST) w_state_nxt = c_ST_READY;
      c_ST_READY: if (clr) w_state_nxt = c_ST_CLEAR;
      default:    w_state_nxt = c_ST_CLEAR;
    endcase
  end

  // A clr request in READY swallows any port access in the same cycle.
  always_comb begin
    busy       = (r_state == c_ST_CLEAR);
    w_clearing = (r_state == c_ST_CLEAR) && !reset;
    w_accept   = (r_state == c_ST_READY) && !clr && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (w_clearing) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end else begin
      r_clr_cnt <= '0;
    end
  end

  assign w_wr_fire = w_accept && wr_en;
  assign w_rd_fire = w_accept && rd_en;
  assign w_merged  = (wdata & wmask) | (r_mem[waddr] & ~wmask);
  assign w_rd_word = ((RD_MODE == 1) && w_wr_fire && (waddr == raddr)) ? w_merged : r_mem[raddr];

  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_fire) begin
      r_mem[waddr] <= w_merged;
    end
  end

  // Data is captured on the issuing edge so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_fire;
      if (w_rd_fire) r_s1_data <= w_rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_data  <= r_s1_data;
        end
      end
      assign w_out_valid = r_s2_valid;
      assign w_out_data  = r_s2_data;
    end else begin : g_lat1
      assign w_out_valid = r_s1_valid;
      assign w_out_data  = r_s1_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= w_out_valid;
      if (w_out_valid) rdata <= w_out_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
// ============================================================================
// Module   : tb_ram_dp_clr
// Brief    : Randomised scoreboard bench for ram_dp_clr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_dp_clr;

  parameter int RD_MODE    = 0;
  parameter int RD_LATENCY = 1;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, clr, busy, wr_en, rd_en, rvalid;
  logic [3:0] waddr, raddr;
  logic [7:0] wdata, wmask, rdata;

  ram_dp_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_MODE(RD_MODE), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ref_mem [DEPTH];
  int         left;
  logic [7:0] q_data [$];
  int         q_cyc [$];
  logic [7:0] last_rdata;
  int         n_vec = 0;
  int         n_err = 0;
  bit         done = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic zero_mem();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // Applies the rules for the upcoming edge to the reference model.
  task automatic model_step();
    logic [7:0] merged;
    if (reset) begin
      left = DEPTH;
      zero_mem();
      q_data.delete();
      q_cyc.delete();
      last_rdata = 8'h00;
    end else if (left > 0) begin
      left--;
    end else if (clr) begin
      left = DEPTH;
      zero_mem();
    end else begin
      merged = (wdata & wmask) | (ref_mem[waddr] & ~wmask);
      if (rd_en) begin
        q_data.push_back((RD_MODE == 1 && wr_en && waddr == raddr) ? merged : ref_mem[raddr]);
        q_cyc.push_back(cyc + 1 + RD_LATENCY);
      end
      if (wr_en) ref_mem[waddr] = merged;
    end
  endtask

  task automatic drive(input logic rs, input logic cl, input logic we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic [7:0] wm, input logic re,
                       input logic [3:0] ra);
    @(negedge clk);
    reset = rs; clr = cl; wr_en = we; waddr = wa; wdata = wd; wmask = wm;
    rd_en = re; raddr = ra;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    drive(0, 0, 1, a, d, m, 0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(0, 0, 0, 4'd0, 8'h00, 8'h00, 1, a);
  endtask

  task automatic rnd_cycle(input int clr_odds);
    logic [3:0] wa, ra;
    wa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
    ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
    drive(0, ($urandom_range(0, clr_odds) == 0), 1'($urandom), wa, 8'($urandom),
          8'($urandom), 1'($urandom), ra);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
  endtask

  // Monitor: compares outputs just after each edge against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        check("busy", {7'd0, busy}, {7'd0, (left > 0)});
        while (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
          check("rd_missing", 8'd0, 8'd1);
          void'(q_data.pop_front());
          void'(q_cyc.pop_front());
        end
        if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
          check("rvalid", {7'd0, rvalid}, 8'd1);
          check("rdata", rdata, q_data[0]);
          last_rdata = q_data[0];
          void'(q_data.pop_front());
          void'(q_cyc.pop_front());
        end else begin
          check("rvalid_idle", {7'd0, rvalid}, 8'd0);
          check("rdata_hold", rdata, last_rdata);
        end
      end
    end
  end

  initial begin
    reset = 1; clr = 0; wr_en = 0; rd_en = 0;
    waddr = '0; raddr = '0; wdata = '0; wmask = '0;
    model_step();
    drive(1, 0, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0);
    // Port activity during the clear must be ignored.
    for (int i = 0; i < DEPTH; i++) rnd_cycle(3);
    read_all();
    idle(3);

    wr(4'd3, 8'hA5, 8'hFF);
    rd(4'd3);
    idle(4);

    wr(4'd7, 8'hFF, 8'hFF);
    wr(4'd7, 8'h00, 8'h0F);
    rd(4'd7);
    wr(4'd7, 8'hAA, 8'h00);
    rd(4'd7);
    idle(3);

    wr(4'd5, 8'h11, 8'hFF);
    drive(0, 0, 1, 4'd5, 8'h22, 8'hFF, 1, 4'd5);
    rd(4'd5);
    idle(3);

    // Write-after-read to the same address must not leak into the read.
    rd(4'd5);
    wr(4'd5, 8'h33, 8'hFF);
    idle(3);

    rd(4'd9);
    drive(0, 1, 1, 4'd2, 8'h77, 8'hFF, 1, 4'd2);
    for (int i = 0; i < DEPTH; i++) rnd_cycle(3);
    read_all();
    idle(3);

    for (int i = 0; i < 400; i++) rnd_cycle(60);
    idle(DEPTH + 2);

    // Reset hitting an in-flight read, then again mid-clear.
    wr(4'd4, 8'h5A, 8'hFF);
    rd(4'd4);
    drive(1, 0, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0);
    idle(7);
    drive(1, 0, 0, 4'd0, 8'h00, 8'h00, 1, 4'd4);
    idle(DEPTH);
    read_all();
    idle(4);

    check("drain", 8'(q_cyc.size()), 8'd0);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
